// File: rtl/serial_sub_pkg.sv
// Shared state encoding for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub_full_sub.sv
// One-bit full subtractor cell (a - b - bin), gate-level form matching the adder's full-adder cell.
module serial_sub_full_sub (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    logic a_x_b;

    assign a_x_b = a ^ b;
    assign d     = a_x_b ^ bin;
    assign bout  = (~a & b) | (~a_x_b & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: D = A - B, one bit per clock, LSB first, with start/busy/done handshake.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W:0]   D,
    output logic         borrow,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(W);

    state_t          state_reg;
    logic [W-1:0]    ra_reg;
    logic [W-1:0]    rb_reg;
    logic [W-1:0]    rd_reg;
    logic            bf_reg;
    logic [CW-1:0]   cnt_reg;

    logic            d_bit;
    logic            bout;

    serial_sub_full_sub u_full_sub (
        .a    (ra_reg[0]),
        .b    (rb_reg[0]),
        .bin  (bf_reg),
        .d    (d_bit),
        .bout (bout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            ra_reg    <= '0;
            rb_reg    <= '0;
            rd_reg    <= '0;
            bf_reg    <= 1'b0;
            cnt_reg   <= '0;
            D         <= '0;
            borrow    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        ra_reg    <= A;
                        rb_reg    <= B;
                        bf_reg    <= 1'b0;
                        cnt_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    ra_reg  <= ra_reg >> 1;
                    rb_reg  <= rb_reg >> 1;
                    rd_reg  <= {d_bit, rd_reg[W-1:1]};
                    bf_reg  <= bout;
                    cnt_reg <= cnt_reg + CW'(1);
                    // Last bit: publish the result together with the final borrow as sign.
                    if (cnt_reg == CW'(W - 1)) begin
                        D         <= {bout, d_bit, rd_reg[W-1:1]};
                        borrow    <= bout;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        ra_reg    <= A;
                        rb_reg    <= B;
                        bf_reg    <= 1'b0;
                        cnt_reg   <= '0;
                        busy      <= 1'b1;
                        state_reg <= RUN;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: expected differences queued at start, checked on each done pulse.
module tb_serial_sub;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W:0]   D;
    logic         borrow;
    logic         busy;
    logic         done;

    int checks;
    int errors;
    logic [W:0] sb[$];

    serial_sub #(.W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .A      (A),
        .B      (B),
        .D      (D),
        .borrow (borrow),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        return {1'b0, a} - {1'b0, b};
    endfunction

    // Monitor: every done pulse pops one expected result.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                logic [W:0] e;
                e = sb.pop_front();
                $display("result D=%b borrow=%b expected D=%b", D, borrow, e);
                check("result_D", 32'(D), 32'(e));
                check("result_borrow", 32'(borrow), 32'(e[W]));
            end
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int lat;
        int nb;
        logic got;
        logic [W:0] e;
        @(posedge clk); #1;
        e = model(a, b);
        A = a; B = b; start = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; nb = 0; got = 1'b0;
        while (!got && lat < W + 6) begin
            @(negedge clk);
            lat++;
            if (busy) nb++;
            if (done) got = 1'b1;
        end
        check("done_timeout", 32'(got), 32'd1);
        check("latency", 32'(lat), 32'(W + 1));
        check("busy_cycles", 32'(nb), 32'(W));
        A = ~a; B = ~b;
        repeat (3) @(negedge clk);
        check("hold_D", 32'(D), 32'(e));
        check("done_low", 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        int pulses;
        checks = 0;
        errors = 0;
        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        repeat (2) @(negedge clk);
        check("rst_D", 32'(D), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(4'd9, 4'd3);
        run_op(4'd3, 4'd9);
        run_op(4'd0, 4'd15);
        run_op(4'd15, 4'd0);
        run_op(4'd7, 4'd7);

        // Second start while running must be ignored.
        @(posedge clk); #1;
        A = 4'd9; B = 4'd3; start = 1'b1;
        sb.push_back(model(4'd9, 4'd3));
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        A = 4'd1; B = 4'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; A = '0; B = '0;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("midrun_pulses", 32'(pulses), 32'd1);

        // Start held high: back-to-back results one DONE cycle apart.
        @(posedge clk); #1;
        A = 4'd5; B = 4'd2; start = 1'b1;
        sb.push_back(model(4'd5, 4'd2));
        sb.push_back(model(4'd2, 4'd5));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        check("b2b_first_done", 32'(done), 32'd1);
        A = 4'd2; B = 4'd5;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
        end while (!done && n < 20);
        check("b2b_second_done", 32'(done), 32'd1);
        check("b2b_gap", 32'(n), 32'(W + 1));

        // Asynchronous reset during the second RUN cycle.
        @(posedge clk); #1;
        A = 4'd9; B = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_D", 32'(D), 32'd0);
        check("async_rst_borrow", 32'(borrow), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        start = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_dominates_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        rst = 1'b0;
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("no_done_after_abort", 32'(pulses), 32'd0);

        run_op(4'd6, 4'd11);
        run_op(4'd12, 4'd5);

        repeat (2) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
